alu_muldiv: RTL and testbench
=============================

// Module: alu_muldiv
// PURPOSE
//  Next-generation datapath ALU: width-parametrised single-cycle ALU plus an iterative
//  multiply/divide unit with HI/LO registers. Sits in the EX stage of the multi-cycle CPU.
//  The controller issues MULT/DIV with start and stalls on busy; MFHI/MFLO read results via C.
// PARAMETERS
//  WIDTH    32              datapath width (even, >=8)
//  SHAMT_W  $clog2(WIDTH)   shift-amount bits taken from A
// PORTS
//  clk    in   1      clock, rising edge
//  rstn   in   1      asynchronous, active-low reset
//  A      in   WIDTH  operand A (signed view for SLT/MULT/DIV)
//  B      in   WIDTH  operand B
//  ALUOp  in   5      operation code (shared encode package)
//  start  in   1      launch MULT/MULTU/DIV/DIVU/MTHI/MTLO; sampled only when busy=0
//  C      out  WIDTH  combinational result
//  Zero   out  1      C == 0
//  busy   out  1      iterative operation in progress
//  done   out  1      one-cycle pulse: HI/LO just updated by MULT/DIV
//  hi     out  WIDTH  HI register
//  lo     out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (rstn=0, async): hi=lo=0, busy=0, done=0, FSM=IDLE. Mid-op reset aborts; no done.
//  - Combinational ops, valid every cycle incl. while busy: NOP(C=A), ADD, SUB, AND, OR,
//    XOR, NOR, SLT (signed), SLTU, SLL/SRL/SRA (C=B shifted by A[SHAMT_W-1:0]),
//    LUI (C={B[WIDTH/2-1:0], WIDTH/2 zeros}). Wrap-around add/sub, no overflow flag.
//    MFHI: C=hi; MFLO: C=lo (current register value, stale while busy).
//    MULT/DIV/MTHI/MTLO ops and undefined codes: C=A.
//  - MTHI/MTLO: start=1 & busy=0 -> hi (or lo) <= A at that edge; no busy, no done.
//  - FSM: IDLE -> MUL or DIV on start & busy=0 & op in {MULT,MULTU,DIV,DIVU};
//    operands and signedness latched at the accept edge (k).
//    MUL/DIV: one iteration per cycle, WIDTH iterations; then FINISH.
//    FINISH -> IDLE: at edge k+WIDTH+1, hi/lo written, busy falls, done=1 for one cycle.
//    busy=1 from edge k+1 through edge k+WIDTH+1.
//  - start while busy=1: ignored entirely (no queueing, hi/lo untouched).
//  - start in the same cycle that done is high: accepted normally (back-to-back).
//  - Multiply: shift-add on magnitudes; signed result negated if sign(A)^sign(B).
//    {hi,lo} = full 2*WIDTH-bit product.
//  - Divide: restoring, on magnitudes; lo=quotient, hi=remainder.
//    Signed: quotient negated if sign(A)^sign(B); remainder takes sign of dividend.
//    MIN/-1: lo=MIN, hi=0. Divide by zero: lo=all ones, hi=A, full latency, no fault.
//  - Zero is purely combinational from C.
// STRUCTURE
//  - Shared package (ctrl_encode_def): ALUOp widened to 5 bits; existing ALU_* codes kept;
//    add ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO;
//    FSM state encodings MD_IDLE, MD_MUL, MD_DIV, MD_FINISH.
//  - One sub-module: muldiv_core (FSM, iteration counter, partial regs, sign fix-up,
//    start/busy/done). Top holds the combinational ALU mux, hi/lo and the MT* writes.
// TESTING (WIDTH=32 unless stated)
//  1 MULTU A=B=0xFFFFFFFF, start 1 cycle -> done exactly 33 cycles after accept edge;
//    hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles.
//  2 MULT A=-3, B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV A=-7, B=2 -> lo=0xFFFFFFFD,
//    hi=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
//  3 DIVU A=5, B=0 -> lo=0xFFFFFFFF, hi=5 after 33 cycles; MFLO then gives C=0xFFFFFFFF, Zero=0.
//  4 start DIVU mid-MULT -> ignored, MULT result intact; start held on done cycle -> second
//    op accepted back-to-back. rstn low at cycle 10 of an op -> busy=0, hi=lo=0, no done.
//  5 MTHI A=0x1234 then MFHI -> C=0x1234; MTLO while busy -> lo unchanged.
//  6 Regression: SRA B=0x80000000, A=4 -> C=0xF8000000; SUB 5-5 -> C=0, Zero=1;
//    SLT -1<1 -> C=1; SLTU 0xFFFFFFFF<1 -> C=0; repeat test 1 with WIDTH=16.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// ============================================================================
//  Module      : ctrl_encode_def (package)
//  Description : Shared ALU operation codes and multiply/divide FSM encodings.
//  Revision    : 1.0 - 5-bit ALUOp with multiply/divide and HI/LO access ops
// ============================================================================
`default_nettype none

package ctrl_encode_def;

    localparam logic [4:0] ALU_NOP   = 5'd0;
    localparam logic [4:0] ALU_ADD   = 5'd1;
    localparam logic [4:0] ALU_SUB   = 5'd2;
    localparam logic [4:0] ALU_AND   = 5'd3;
    localparam logic [4:0] ALU_OR    = 5'd4;
    localparam logic [4:0] ALU_SLT   = 5'd5;
    localparam logic [4:0] ALU_SLTU  = 5'd6;
    localparam logic [4:0] ALU_XOR   = 5'd7;
    localparam logic [4:0] ALU_NOR   = 5'd8;
    localparam logic [4:0] ALU_SLL   = 5'd9;
    localparam logic [4:0] ALU_SRL   = 5'd10;
    localparam logic [4:0] ALU_SRA   = 5'd11;
    localparam logic [4:0] ALU_LUI   = 5'd12;
    localparam logic [4:0] ALU_MULT  = 5'd13;
    localparam logic [4:0] ALU_MULTU = 5'd14;
    localparam logic [4:0] ALU_DIV   = 5'd15;
    localparam logic [4:0] ALU_DIVU  = 5'd16;
    localparam logic [4:0] ALU_MFHI  = 5'd17;
    localparam logic [4:0] ALU_MFLO  = 5'd18;
    localparam logic [4:0] ALU_MTHI  = 5'd19;
    localparam logic [4:0] ALU_MTLO  = 5'd20;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'd0,
        MD_MUL    = 2'd1,
        MD_DIV    = 2'd2,
        MD_FINISH = 2'd3
    } md_state_t;

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_core.sv
// ============================================================================
//  Module      : muldiv_core
//  Description : Iterative shift-add multiplier / restoring divider, one
//                iteration per cycle, with sign fix-up and busy/done control.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_core
    import ctrl_encode_def::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             wr,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_t        r_state;
    md_state_t        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_a;
    logic             r_mul;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_done;

    logic             w_is_mul;
    logic             w_is_div;
    logic             w_signed;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_ma;
    logic [WIDTH-1:0] w_mb;
    logic [WIDTH:0]   w_msum;
    logic [WIDTH:0]   w_dshift;
    logic             w_dge;
    logic [WIDTH-1:0] w_drem;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    assign w_is_mul = is_mul_op(op);
    assign w_is_div = is_div_op(op);
    assign w_signed = (op == ALU_MULT) || (op == ALU_DIV);
    assign w_accept = (r_state == MD_IDLE) && start && (w_is_mul || w_is_div);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Iterations run on magnitudes; signs are reapplied in FINISH.
    assign w_ma = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_mb = (w_signed && b[WIDTH-1]) ? -b : b;

    assign w_msum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_dshift = {r_hi, r_lo[WIDTH-1]};
    assign w_dge    = (w_dshift >= {1'b0, r_b});
    assign w_drem   = w_dge ? WIDTH'(w_dshift - {1'b0, r_b}) : w_dshift[WIDTH-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            MD_IDLE:   if (w_accept) w_next = w_is_mul ? MD_MUL : MD_DIV;
            MD_MUL,
            MD_DIV:    if (w_last) w_next = MD_FINISH;
            MD_FINISH: w_next = MD_IDLE;
            default:   w_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_mul   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == MD_FINISH);
            case (r_state)
                MD_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_hi    <= '0;
                        r_lo    <= w_ma;
                        r_b     <= w_mb;
                        r_a     <= a;
                        r_mul   <= w_is_mul;
                        r_neg_q <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r <= w_signed && a[WIDTH-1];
                        r_dz    <= w_is_div && (b == '0);
                    end
                end
                MD_MUL: begin
                    r_hi  <= w_msum[WIDTH:1];
                    r_lo  <= {w_msum[0], r_lo[WIDTH-1:1]};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                MD_DIV: begin
                    r_hi  <= w_drem;
                    r_lo  <= {r_lo[WIDTH-2:0], w_dge};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign w_prod = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quo  = r_neg_q ? -r_lo : r_lo;
    assign w_rem  = r_neg_r ? -r_hi : r_hi;

    // Divide by zero bypasses the fix-up: quotient all ones, remainder = raw A.
    always_comb begin
        res_hi = w_rem;
        res_lo = w_quo;
        if (r_mul) begin
            res_hi = w_prod[2*WIDTH-1:WIDTH];
            res_lo = w_prod[WIDTH-1:0];
        end else if (r_dz) begin
            res_hi = r_a;
            res_lo = '1;
        end
    end

    assign wr   = (r_state == MD_FINISH);
    assign busy = (r_state != MD_IDLE);
    assign done = r_done;

endmodule

`default_nettype wire

// File: rtl/alu_muldiv.sv
// ============================================================================
//  Module      : alu_muldiv
//  Description : Single-cycle ALU with HI/LO registers fed by an iterative
//                multiply/divide core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv
    import ctrl_encode_def::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       ALUOp,
    input  logic             start,
    output logic [WIDTH-1:0] C,
    output logic             Zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               w_busy;
    logic               w_core_wr;
    logic [WIDTH-1:0]   w_core_hi;
    logic [WIDTH-1:0]   w_core_lo;
    logic [SHAMT_W-1:0] w_shamt;

    muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .op     (ALUOp),
        .a      (A),
        .b      (B),
        .busy   (w_busy),
        .done   (done),
        .wr     (w_core_wr),
        .res_hi (w_core_hi),
        .res_lo (w_core_lo)
    );

    // Core write-back only happens while busy, so it never collides with MT*.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_core_wr) begin
            r_hi <= w_core_hi;
            r_lo <= w_core_lo;
        end else if (start && !w_busy) begin
            if (ALUOp == ALU_MTHI) r_hi <= A;
            if (ALUOp == ALU_MTLO) r_lo <= A;
        end
    end

    assign w_shamt = A[SHAMT_W-1:0];

    always_comb begin
        C = A;
        case (ALUOp)
            ALU_ADD:  C = A + B;
            ALU_SUB:  C = A - B;
            ALU_AND:  C = A & B;
            ALU_OR:   C = A | B;
            ALU_XOR:  C = A ^ B;
            ALU_NOR:  C = ~(A | B);
            ALU_SLT:  C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: C = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_SLL:  C = B << w_shamt;
            ALU_SRL:  C = B >> w_shamt;
            ALU_SRA:  C = $unsigned($signed(B) >>> w_shamt);
            ALU_LUI:  C = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            ALU_MFHI: C = r_hi;
            ALU_MFLO: C = r_lo;
            default:  C = A;
        endcase
    end

    assign Zero = (C == '0);
    assign busy = w_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv.sv
// ============================================================================
//  Module      : tb_alu_muldiv
//  Description : Directed table-driven bench for alu_muldiv (WIDTH 32 and 16).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_muldiv;
    import ctrl_encode_def::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] A, B, C, hi, lo;
    logic [4:0]  op;
    logic        start, Zero, busy, done;

    logic [15:0] A16, B16, C16, hi16, lo16;
    logic [4:0]  op16;
    logic        start16, Zero16, busy16, done16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .A(A), .B(B), .ALUOp(op), .start(start),
        .C(C), .Zero(Zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    alu_muldiv #(.WIDTH(16)) dut16 (
        .clk(clk), .rstn(rstn), .A(A16), .B(B16), .ALUOp(op16), .start(start16),
        .C(C16), .Zero(Zero16), .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        z;
    } alu_vec_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } md_vec_t;

    alu_vec_t av[16];
    md_vec_t  mv[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = ALU_NOP;
    endtask

    // Counts negedges until done (bounded); busy counted including the current cycle.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end
    endtask

    initial begin
        int lat, bcnt, dcnt;

        av[0]  = '{ALU_ADD,  32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0};
        av[1]  = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        av[2]  = '{ALU_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1};
        av[3]  = '{ALU_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0};
        av[4]  = '{ALU_OR,   32'hF000_0001, 32'h0000_0010, 32'hF000_0011, 1'b0};
        av[5]  = '{ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0};
        av[6]  = '{ALU_NOR,  32'h0000_FFFF, 32'hFF00_0000, 32'h00FF_0000, 1'b0};
        av[7]  = '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
        av[8]  = '{ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        av[9]  = '{ALU_SLL,  32'h0000_0004, 32'h0000_0081, 32'h0000_0810, 1'b0};
        av[10] = '{ALU_SRL,  32'h0000_0004, 32'h8000_0000, 32'h0800_0000, 1'b0};
        av[11] = '{ALU_SRA,  32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 1'b0};
        av[12] = '{ALU_LUI,  32'h0000_0000, 32'hABCD_1234, 32'h1234_0000, 1'b0};
        av[13] = '{ALU_NOP,  32'h1357_9BDF, 32'h0000_0000, 32'h1357_9BDF, 1'b0};
        av[14] = '{ALU_MULT, 32'h0000_0042, 32'h0000_0007, 32'h0000_0042, 1'b0};
        av[15] = '{5'h1F,    32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 1'b1};

        mv[0] = '{ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        mv[1] = '{ALU_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        mv[2] = '{ALU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        mv[3] = '{ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        mv[4] = '{ALU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        mv[5] = '{ALU_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        mv[6] = '{ALU_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};

        rstn = 1'b0; start = 1'b0; op = ALU_NOP; A = '0; B = '0;
        start16 = 1'b0; op16 = ALU_NOP; A16 = '0; B16 = '0;
        repeat (2) @(negedge clk);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);
        rstn = 1'b1;

        foreach (av[i]) begin
            @(negedge clk);
            op = av[i].op; A = av[i].a; B = av[i].b;
            #1;
            chk($sformatf("alu%0d_C", i), C, av[i].c);
            chk($sformatf("alu%0d_Zero", i), {31'b0, Zero}, {31'b0, av[i].z});
        end

        foreach (mv[i]) begin
            issue(mv[i].op, mv[i].a, mv[i].b);
            wait_done(lat, bcnt);
            chk($sformatf("md%0d_latency", i), lat, 33);
            chk($sformatf("md%0d_busy_cycles", i), bcnt, 33);
            chk($sformatf("md%0d_hi", i), hi, mv[i].hi);
            chk($sformatf("md%0d_lo", i), lo, mv[i].lo);
            @(negedge clk);
            chk($sformatf("md%0d_done_pulse", i), {31'b0, done}, 32'h0);
        end

        // Divide by zero then MFLO/MFHI.
        issue(ALU_DIVU, 32'h5, 32'h0);
        wait_done(lat, bcnt);
        chk("divu0_latency", lat, 33);
        op = ALU_MFLO; #1;
        chk("mflo_C", C, 32'hFFFF_FFFF);
        chk("mflo_Zero", {31'b0, Zero}, 32'h0);
        op = ALU_MFHI; #1;
        chk("mfhi_C", C, 32'h5);

        // start while busy is ignored; start on the done cycle is accepted.
        issue(ALU_MULT, 32'hFFFF_FFFD, 32'h7);
        repeat (5) @(negedge clk);
        op = ALU_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = ALU_NOP;
        wait_done(lat, bcnt);
        chk("ignore_latency", 6 + lat, 33);
        chk("ignore_hi", hi, 32'hFFFF_FFFF);
        chk("ignore_lo", lo, 32'hFFFF_FFEB);
        op = ALU_MULTU; A = 32'd6; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = ALU_NOP;
        chk("b2b_busy", {31'b0, busy}, 32'h1);
        wait_done(lat, bcnt);
        chk("b2b_latency", lat, 33);
        chk("b2b_hi", hi, 32'h0);
        chk("b2b_lo", lo, 32'd42);

        // MTLO while busy must not touch lo.
        issue(ALU_MULTU, 32'd2, 32'd3);
        op = ALU_MTLO; A = 32'hDEAD; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = ALU_NOP;
        chk("mtlo_busy_lo", lo, 32'd42);
        wait_done(lat, bcnt);
        chk("mtlo_busy_final_lo", lo, 32'd6);

        // MTHI then MFHI.
        @(negedge clk);
        op = ALU_MTHI; A = 32'h1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = ALU_MFHI; A = 32'h0;
        #1;
        chk("mthi_mfhi_C", C, 32'h1234);
        chk("mthi_no_busy", {31'b0, busy}, 32'h0);
        chk("mthi_no_done", {31'b0, done}, 32'h0);

        // Reset mid-operation aborts without done.
        issue(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);

        // WIDTH=16 full-magnitude unsigned multiply.
        @(negedge clk);
        op16 = ALU_MULTU; A16 = 16'hFFFF; B16 = 16'hFFFF; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0; op16 = ALU_NOP;
        lat = 0;
        bcnt = busy16 ? 1 : 0;
        while (!done16 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy16) bcnt++;
        end
        chk("w16_latency", lat, 17);
        chk("w16_busy_cycles", bcnt, 17);
        chk("w16_hi", {16'h0, hi16}, 32'h0000_FFFE);
        chk("w16_lo", {16'h0, lo16}, 32'h0000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
